matrix_column_scanner: RTL and testbench
========================================

Name: matrix_column_scanner

Overview:
- Downstream consumer of the alternate-display mux's five 7-bit column images (column_4..column_0).
- Time-multiplexes the image onto the physical LED matrix: one active column at a time, with a blanking gap between columns to prevent ghosting.
- Double-buffers the image per frame, so a mid-frame change to the inputs never tears the display.
- Generates alternate_selector, which feeds back to the mux's selector input, so that image and water-level views alternate every ALT_FRAMES frames.

Parameters:
- SCAN_DIV, 1000: clock cycles per column slot. Must be ≥ 2.
- BLANK_CYCLES, 50: cycles at the start of each slot during which outputs are blanked. Must be < SCAN_DIV.
- ALT_FRAMES, 500: completed frames between alternate_selector toggles. Must be ≥ 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable; low stops and blanks the matrix.
- column_4  in  7  leftmost column image, bit 6 = top row.
- column_3  in  7  column image.
- column_2  in  7  column image.
- column_1  in  7  column image.
- column_0  in  7  rightmost column image.
- row_out  out  7  row drive for the currently active column, active-high.
- column_select  out  5  one-hot active column, active-high; bit 4 = column_4.
- frame_start  out  1  one-cycle pulse at the first cycle of each frame.
- alternate_selector  out  1  view selector returned to the alternate-display mux.

Behaviour:
- Registered state:
  - active flag.
  - tick counter, width $clog2(SCAN_DIV).
  - column index 4..0.
  - five 7-bit shadow registers.
  - frame counter, width $clog2(ALT_FRAMES)+1.
  - alt toggle.
- All outputs decode only from registered state. There is no combinational path from any input to any output.
- Reset (reset_n low, asynchronous):
  - active=0, tick=0, index=4, shadows=0, frame counter=0, alt=0.
  - Outputs: row_out=0, column_select=0, frame_start=0, alternate_selector=0.
- Idle (active=0): outputs blanked (0). alternate_selector holds its value.
  - At the first edge with enable=1: active←1, tick←0, index←4, all five shadows capture column_4..column_0.
- Running (active=1, enable=1), on each edge:
  - If tick < SCAN_DIV-1: tick←tick+1.
  - Else tick←0 and:
    - If index≠0: index←index-1. Scan order is 4,3,2,1,0.
    - If index=0: index←4, shadows recapture all inputs (frame boundary), frame counter increments.
      - When the frame counter reaches ALT_FRAMES-1 at this boundary: frame counter←0 and alt toggles.
- Output decode while active:
  - tick < BLANK_CYCLES: column_select=0, row_out=0.
  - Otherwise: column_select=one-hot(index), row_out=shadow[index].
  - frame_start = active && index==4 && tick==0.
- Frame timing:
  - Frame length = 5×SCAN_DIV cycles.
  - First frame_start appears in the cycle after the enabling edge, i.e. 1 cycle of latency.
- enable deassert mid-frame:
  - Next edge: active←0, outputs blank from that cycle.
  - Tick, index and frame counter are cleared; alt is held.
  - Re-enable restarts at column 4 with a fresh capture. A partial frame does not count toward ALT_FRAMES.
- Input changes mid-frame affect nothing until the next frame boundary capture.
- Reset asserted mid-slot: outputs go to 0 immediately (asynchronously), regardless of clock.
- SCAN_DIV and BLANK_CYCLES edge values:
  - BLANK_CYCLES=0: no blanking.
  - SCAN_DIV=2 with BLANK_CYCLES=1: alternates blank and lit cycles.

Decomposition:
- Shared package matrix_pkg holds:
  - NUM_COLUMNS=5, NUM_ROWS=7, FIRST_COLUMN=4.
  - typedef column_index_t (logic [2:0]).
  - typedef column_image_t (logic [6:0]).
- One sub-module, matrix_scan_tick:
  - Parameterised SCAN_DIV/BLANK_CYCLES counter with synchronous clear.
  - Outputs slot_end (tick==SCAN_DIV-1) and blanking (tick<BLANK_CYCLES).
- Shadow registers, column index and frame/alt logic remain in the top.

Test Plan (bench parameters SCAN_DIV=4, BLANK_CYCLES=1, ALT_FRAMES=2):
1. Reset, then enable=1 with column_4..0 = 7'h7F, 7'h41, 7'h41, 7'h41, 7'h7F.
   - frame_start pulses 1 cycle after the enabling edge.
   - column_select sequence per slot: 00000, 10000×3, then 00000, 01000×3, … down to 00001.
   - row_out per lit column: 7F, 41, 41, 41, 7F.
   - Frame period = 20 cycles.
2. Change column_2 to 7'h00 during column 3's slot.
   - Column 2 in the current frame still shows 41.
   - Next frame shows 00.
3. Run 4 full frames from reset.
   - alternate_selector = 0 until the 2nd frame boundary, then 1.
   - Returns to 0 at the 4th boundary.
4. Drop enable during column 1's lit phase.
   - Next cycle: row_out=0, column_select=0.
   - Re-enable: frame_start 1 cycle later, scan restarts at column 4.
   - alternate_selector unchanged; the partial frame is not counted.
5. Assert reset_n low mid-slot between clock edges.
   - All outputs 0 immediately.
   - After release with enable=1, behaviour identical to scenario 1.
6. Invariant checks on every cycle:
   - column_select is zero-or-one-hot at all times.
   - row_out=0 whenever column_select=0.
   - frame_start is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared sizing constants and types for the LED matrix column scanner.
package matrix_pkg;
   typedef logic [2:0] column_index_t;
   typedef logic [6:0] column_image_t;

   localparam int            NUM_COLUMNS  = 5;
   localparam int            NUM_ROWS     = 7;
   localparam column_index_t FIRST_COLUMN = 3'd4;
endpackage

// File: rtl/matrix_scan_tick.sv
// Column slot timer: counts SCAN_DIV cycles per slot and flags the
// blanking window at the start of each slot.
module matrix_scan_tick #(
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 50
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_clear,
   output logic o_slot_start,
   output logic o_slot_end,
   output logic o_blanking
);
   localparam int            TW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [TW-1:0] LAST = TW'(SCAN_DIV - 1);

   logic [TW-1:0] r_tick;

   // Free-running slot counter, held at zero while cleared.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)              r_tick <= '0;
      else if (i_clear)          r_tick <= '0;
      else if (r_tick == LAST)   r_tick <= '0;
      else                       r_tick <= r_tick + TW'(1);
   end

   assign o_slot_start = (r_tick == '0);
   assign o_slot_end   = (r_tick == LAST);
   // Signed compare keeps BLANK_CYCLES=0 a clean "never blank".
   assign o_blanking   = (int'(r_tick) < BLANK_CYCLES);
endmodule

// File: rtl/matrix_column_scanner.sv
// Multiplexes a double-buffered 5x7 image onto the LED matrix one column
// at a time, and toggles the mux view selector every ALT_FRAMES frames.
module matrix_column_scanner
   import matrix_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 50,
   parameter int ALT_FRAMES   = 500
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic [NUM_ROWS-1:0]    column_4,
   input  logic [NUM_ROWS-1:0]    column_3,
   input  logic [NUM_ROWS-1:0]    column_2,
   input  logic [NUM_ROWS-1:0]    column_1,
   input  logic [NUM_ROWS-1:0]    column_0,
   output logic [NUM_ROWS-1:0]    row_out,
   output logic [NUM_COLUMNS-1:0] column_select,
   output logic                   frame_start,
   output logic                   alternate_selector
);
   localparam int            FW    = $clog2(ALT_FRAMES) + 1;
   localparam logic [FW-1:0] FLAST = FW'(ALT_FRAMES - 1);

   logic                                  r_active;
   column_index_t                         r_index;
   logic [NUM_COLUMNS-1:0][NUM_ROWS-1:0]  r_shadow;
   logic [FW-1:0]                         r_frame;
   logic                                  r_alt;

   logic                                  w_run;
   logic                                  w_slot_start;
   logic                                  w_slot_end;
   logic                                  w_blanking;
   logic [NUM_COLUMNS-1:0][NUM_ROWS-1:0]  w_inputs;

   assign w_run    = r_active & enable;
   assign w_inputs = {column_4, column_3, column_2, column_1, column_0};

   matrix_scan_tick #(
      .SCAN_DIV     (SCAN_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_tick (
      .clock        (clock),
      .reset_n      (reset_n),
      .i_clear      (~w_run),
      .o_slot_start (w_slot_start),
      .o_slot_end   (w_slot_end),
      .o_blanking   (w_blanking)
   );

   // Scan sequencing: start/stop, column stepping, frame capture and view toggle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_active <= 1'b0;
         r_index  <= FIRST_COLUMN;
         r_shadow <= '0;
         r_frame  <= '0;
         r_alt    <= 1'b0;
      end else if (!r_active) begin
         if (enable) begin
            r_active <= 1'b1;
            r_index  <= FIRST_COLUMN;
            r_shadow <= w_inputs;
         end
      end else if (!enable) begin
         // Abandon the partial frame; only the view selector survives.
         r_active <= 1'b0;
         r_index  <= FIRST_COLUMN;
         r_frame  <= '0;
      end else if (w_slot_end) begin
         if (r_index != '0) begin
            r_index <= r_index - 3'd1;
         end else begin
            r_index  <= FIRST_COLUMN;
            r_shadow <= w_inputs;
            if (r_frame == FLAST) begin
               r_frame <= '0;
               r_alt   <= ~r_alt;
            end else begin
               r_frame <= r_frame + FW'(1);
            end
         end
      end
   end

   // Output decode purely from registered state.
   always_comb begin
      column_select = '0;
      row_out       = '0;
      if (r_active && !w_blanking) begin
         column_select = NUM_COLUMNS'(1) << r_index;
         row_out       = r_shadow[r_index];
      end
      frame_start        = r_active && (r_index == FIRST_COLUMN) && w_slot_start;
      alternate_selector = r_alt;
   end
endmodule

// File: tb/tb_matrix_column_scanner.sv
// Randomized bench for matrix_column_scanner against a frame-position model.
module tb_matrix_column_scanner;
   localparam int SCAN_DIV  = 4;
   localparam int BLANK     = 1;
   localparam int ALT       = 2;
   localparam int FRAME_LEN = 5 * SCAN_DIV;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic [6:0] c4 = '0, c3 = '0, c2 = '0, c1 = '0, c0 = '0;
   logic [6:0] row_out;
   logic [4:0] column_select;
   logic       frame_start;
   logic       alternate_selector;

   int n_vec = 0;
   int n_err = 0;

   // model: position within frame counted in cycles since activation
   bit         m_active;
   int         m_cnt;
   logic [6:0] m_img [5];
   int         m_frames;
   bit         m_alt;
   bit         prev_fs;

   matrix_column_scanner #(
      .SCAN_DIV     (SCAN_DIV),
      .BLANK_CYCLES (BLANK),
      .ALT_FRAMES   (ALT)
   ) dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .enable             (enable),
      .column_4           (c4),
      .column_3           (c3),
      .column_2           (c2),
      .column_1           (c1),
      .column_0           (c0),
      .row_out            (row_out),
      .column_select      (column_select),
      .frame_start        (frame_start),
      .alternate_selector (alternate_selector)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] cur_in(input int k);
      case (k)
         4: return c4;
         3: return c3;
         2: return c2;
         1: return c1;
         default: return c0;
      endcase
   endfunction

   task automatic model_reset();
      m_active = 0; m_cnt = 0; m_frames = 0; m_alt = 0; prev_fs = 0;
      for (int k = 0; k < 5; k++) m_img[k] = '0;
   endtask

   task automatic model_edge();
      if (!m_active) begin
         if (enable) begin
            m_active = 1; m_cnt = 0;
            for (int k = 0; k < 5; k++) m_img[k] = cur_in(k);
         end
      end else if (!enable) begin
         m_active = 0; m_cnt = 0; m_frames = 0;
      end else begin
         m_cnt = (m_cnt + 1) % FRAME_LEN;
         if (m_cnt == 0) begin
            for (int k = 0; k < 5; k++) m_img[k] = cur_in(k);
            m_frames++;
            if (m_frames == ALT) begin
               m_frames = 0;
               m_alt = !m_alt;
            end
         end
      end
   endtask

   task automatic compare();
      int col;
      bit lit;
      logic [4:0] e_sel;
      logic [6:0] e_row;
      col   = 4 - m_cnt / SCAN_DIV;
      lit   = m_active && ((m_cnt % SCAN_DIV) >= BLANK);
      e_sel = lit ? (5'd1 << col) : 5'd0;
      e_row = lit ? m_img[col] : 7'd0;
      check("column_select", 32'(column_select), 32'(e_sel));
      check("row_out", 32'(row_out), 32'(e_row));
      check("frame_start", 32'(frame_start), 32'(m_active && m_cnt == 0));
      check("alt_sel", 32'(alternate_selector), 32'(m_alt));
      check("inv_onehot0", 32'($onehot0(column_select)), 32'd1);
      check("inv_row_blank", 32'((column_select == 0) && (row_out != 0)), 32'd0);
      check("inv_fs_double", 32'(prev_fs && frame_start), 32'd0);
      prev_fs = frame_start;
   endtask

   task automatic cycle();
      @(posedge clock);
      model_edge();
      @(negedge clock);
      compare();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sel"}, 32'(column_select), 32'd0);
      check({tag, "_row"}, 32'(row_out), 32'd0);
      check({tag, "_fs"}, 32'(frame_start), 32'd0);
      check({tag, "_alt"}, 32'(alternate_selector), 32'd0);
   endtask

   task automatic sync_reset();
      @(negedge clock);
      reset_n = 1'b0;
      enable  = 1'b0;
      model_reset();
      #1 check_all_zero("reset");
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic load_scenario1();
      c4 = 7'h7F; c3 = 7'h41; c2 = 7'h41; c1 = 7'h41; c0 = 7'h7F;
   endtask

   initial begin
      int guard;
      model_reset();
      // 1: reset, idle, then the basic scan pattern
      sync_reset();
      cycle(); cycle();
      load_scenario1();
      enable = 1'b1;
      // 2: change column_2 during column 3's slot; new value only next frame
      guard = 0;
      while (!(m_active && m_cnt == 5) && guard < 100) begin cycle(); guard++; end
      check("wait_col3", 32'(guard < 100), 32'd1);
      c2 = 7'h00;
      for (int i = 0; i < 2 * FRAME_LEN + 2; i++) cycle();

      // 3: four full frames from reset, selector toggles at boundaries 2 and 4
      sync_reset();
      c4 = 7'($urandom); c3 = 7'($urandom); c2 = 7'($urandom); c1 = 7'($urandom); c0 = 7'($urandom);
      enable = 1'b1;
      for (int i = 0; i < 4 * FRAME_LEN + 2; i++) cycle();

      // 4: drop enable during column 1's lit phase after one counted frame
      guard = 0;
      while (!(m_frames == 1 && m_cnt == 13) && guard < 200) begin cycle(); guard++; end
      check("wait_col1", 32'(guard < 200), 32'd1);
      enable = 1'b0;
      cycle(); cycle(); cycle();
      enable = 1'b1;
      for (int i = 0; i < 2 * FRAME_LEN + 3; i++) cycle();

      // 5: asynchronous reset between edges, then a replay of scenario 1
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1 check_all_zero("async_rst");
      model_reset();
      @(negedge clock);
      load_scenario1();
      enable  = 1'b1;
      reset_n = 1'b1;
      for (int i = 0; i < FRAME_LEN + 5; i++) cycle();

      // randomized mix of image updates and enable drops
      for (int i = 0; i < 600; i++) begin
         cycle();
         if ($urandom_range(7) == 0) begin
            case ($urandom_range(4))
               0: c0 = 7'($urandom);
               1: c1 = 7'($urandom);
               2: c2 = 7'($urandom);
               3: c3 = 7'($urandom);
               default: c4 = 7'($urandom);
            endcase
         end
         enable = ($urandom_range(39) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
